// File: rtl/fb_writer.sv
// Frame-buffer writer: accepts (x, y, colour) beats, drops out-of-range ones,
// and issues linear-address writes through a two-stage stallable pipeline.
module fb_writer #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COLOR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        x_coord,
  input  logic [10:0]        y_coord,
  input  logic [COLOR_W-1:0] color,
  output logic               wr_en,
  input  logic               mem_ready,
  output logic [16:0]        wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               frame_done,
  output logic [15:0]        drop_count
);

  localparam int unsigned FRAME_PIXELS = H_RES * V_RES;
  localparam logic [16:0] LAST_ADDR    = 17'(FRAME_PIXELS - 1);

  // Linear address; the product is formed at 32 bits so nothing is lost before narrowing.
  function automatic logic [16:0] pixel_addr(input logic [10:0] x, input logic [10:0] y);
    return 17'(32'(y) * 32'(H_RES) + 32'(x));
  endfunction

  logic               a_valid_r;
  logic [10:0]        a_x_r;
  logic [10:0]        a_y_r;
  logic [COLOR_W-1:0] a_color_r;

  logic               wr_en_r;
  logic [16:0]        wr_addr_r;
  logic [COLOR_W-1:0] wr_data_r;
  logic               frame_done_r;
  logic [15:0]        drop_count_r;

  logic in_range_s;
  logic b_complete_s;
  logic a_advance_s;
  logic in_ready_s;
  logic load_a_s;
  logic drop_s;

  // Handshake and pipeline-advance decisions.
  always_comb begin
    in_range_s   = 1'b0;
    b_complete_s = 1'b0;
    a_advance_s  = 1'b0;
    in_ready_s   = 1'b0;
    load_a_s     = 1'b0;
    drop_s       = 1'b0;
    if ((32'(x_coord) < 32'(H_RES)) && (32'(y_coord) < 32'(V_RES))) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
    b_complete_s = wr_en_r && mem_ready;
    a_advance_s  = a_valid_r && (!wr_en_r || mem_ready);
    in_ready_s   = !a_valid_r || a_advance_s;
    if (in_valid && in_ready_s) begin
      load_a_s = in_range_s;
      drop_s   = !in_range_s;
    end else begin
      load_a_s = 1'b0;
      drop_s   = 1'b0;
    end
  end

  // Stage A: holds one accepted in-range beat until stage B can take it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_valid_r <= 1'b0;
      a_x_r     <= 11'd0;
      a_y_r     <= 11'd0;
      a_color_r <= '0;
    end else if (load_a_s) begin
      a_valid_r <= 1'b1;
      a_x_r     <= x_coord;
      a_y_r     <= y_coord;
      a_color_r <= color;
    end else if (a_advance_s) begin
      a_valid_r <= 1'b0;
    end else begin
      a_valid_r <= a_valid_r;
    end
  end

  // Stage B: the outstanding write; frozen while memory stalls it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= 17'd0;
      wr_data_r <= '0;
    end else if (a_advance_s) begin
      wr_en_r   <= 1'b1;
      wr_addr_r <= pixel_addr(a_x_r, a_y_r);
      wr_data_r <= a_color_r;
    end else if (b_complete_s) begin
      wr_en_r   <= 1'b0;
    end else begin
      wr_en_r   <= wr_en_r;
    end
  end

  // End-of-frame pulse and saturating drop counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_done_r <= 1'b0;
      drop_count_r <= 16'd0;
    end else begin
      frame_done_r <= b_complete_s && (wr_addr_r == LAST_ADDR);
      if (drop_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end else begin
        drop_count_r <= drop_count_r;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign frame_done = frame_done_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: a driver pushes expected writes computed from
// the pixel rules, a separate monitor pops and compares each completed write.
module tb_fb_writer;

  localparam int H    = 320;
  localparam int V    = 240;
  localparam int LAST = H * V - 1;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] x_coord;
  logic [10:0] y_coord;
  logic [7:0]  color;
  logic        wr_en;
  logic        mem_ready;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_done;
  logic [15:0] drop_count;

  fb_writer #(.H_RES(H), .V_RES(V), .COLOR_W(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_coord(x_coord), .y_coord(y_coord), .color(color), .wr_en(wr_en),
    .mem_ready(mem_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .drop_count(drop_count)
  );

  typedef struct { int addr; int data; } wr_t;
  wr_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int drops = 0;
  int cyc = 0;
  int mem_mode = 0;   // 0: always ready, 1: random, 2: held low
  int wr_seen = 0;
  int last_wr_cyc = -1;
  int fd_pulses = 0;
  int last_waits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: in-range beats become writes, the rest are counted.
  task automatic model_accept(input int x, input int y, input int c);
    wr_t w;
    if (x < H && y < V) begin
      w.addr = y * H + x;
      w.data = c & 255;
      sb.push_back(w);
    end else if (drops < 65535) begin
      drops++;
    end
  endtask

  // Present one beat from posedge+1 and hold it until accepted.
  task automatic beat(input int x, input int y, input int c, output int acc_edge);
    int waits = 0;
    bit done = 0;
    acc_edge = -1;
    in_valid = 1'b1;
    x_coord  = 11'(x);
    y_coord  = 11'(y);
    color    = 8'(c);
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        done = 1;
        acc_edge = cyc + 1;
        model_accept(x, y, c);
      end else begin
        waits++;
        if (waits > 1000) begin
          n_chk++;
          n_fail++;
          $display("FAIL accept_timeout: beat (%0d,%0d) not accepted in 1000 cycles", x, y);
          done = 1;
        end
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    last_waits = waits;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || wr_en) && n < 2000) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    case (mem_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = 1'($urandom_range(0, 1));
      default: mem_ready = 1'b0;
    endcase
  end

  // Monitor: checks every completed write, stall stability and frame_done.
  initial begin
    bit   prev_stall = 0;
    bit   fd_pending = 0;
    bit   fd_next;
    logic [16:0] prev_addr = 0;
    logic [7:0]  prev_data = 0;
    wr_t  e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 0;
        fd_pending = 0;
      end else begin
        chk("frame_done", frame_done, fd_pending);
        if (frame_done) fd_pulses++;
        fd_next = 0;
        if (wr_en) begin
          wr_seen++;
          last_wr_cyc = cyc;
          if (prev_stall) begin
            chk("stall_wr_addr", wr_addr, prev_addr);
            chk("stall_wr_data", wr_data, prev_data);
          end
        end
        if (wr_en && mem_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data %0h with no write expected", wr_addr, wr_data);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
            fd_next = (e.addr == LAST);
          end
        end
        prev_stall = wr_en && !mem_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
        fd_pending = fd_next;
      end
    end
  end

  initial begin
    int acc;
    int base;
    int waits_sum;
    reset = 1'b1;
    in_valid = 1'b0;
    x_coord = 11'd0;
    y_coord = 11'd0;
    color = 8'd0;
    mem_ready = 1'b1;
    #2;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_drop_count", drop_count, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clock);
    #1;

    // Single beat latency and address.
    base = wr_seen;
    beat(5, 2, 8'hA5, acc);
    drain();
    chk("single_write_count", wr_seen - base, 1);
    chk("single_latency_cycle", last_wr_cyc, acc + 1);

    // Out-of-range beats, then saturation.
    base = wr_seen;
    beat(320, 0, 1, acc);
    beat(0, 240, 2, acc);
    beat(2047, 2047, 3, acc);
    @(negedge clock);
    chk("drop_no_write", wr_seen - base, 0);
    chk("drop_count_3", drop_count, drops);
    @(posedge clock);
    #1;
    for (int i = 0; i < 65532; i++) begin
      if (i % 2 == 0) beat(320 + $urandom_range(0, 1727), $urandom_range(0, 2047), i, acc);
      else            beat($urandom_range(0, 2047), 240 + $urandom_range(0, 1807), i, acc);
    end
    @(negedge clock);
    chk("drop_count_at_max", drop_count, drops);
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) beat(2047, 0, i, acc);
    @(negedge clock);
    chk("drop_count_saturated", drop_count, 16'hFFFF);
    chk("drop_no_write_total", wr_seen - base, 0);

    // Mid-operation reset with both stages full.
    @(posedge clock);
    #1;
    mem_mode = 2;
    @(posedge clock);
    #1;
    beat(10, 10, 8'h11, acc);
    beat(11, 10, 8'h22, acc);
    chk("prereset_wr_en", wr_en, 1);
    #2;
    reset = 1'b1;
    sb.delete();
    drops = 0;
    #1;
    chk("midreset_wr_en", wr_en, 0);
    chk("midreset_drop_count", drop_count, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_frame_done", frame_done, 0);
    mem_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    beat(7, 3, 8'h5C, acc);
    chk("post_reset_first_edge_accept", last_waits, 0);
    drain();
    @(negedge clock);
    chk("post_reset_in_ready", in_ready, 1);
    @(posedge clock);
    #1;

    // Backpressure: 5 stalled cycles, then random memory readiness.
    mem_mode = 2;
    @(posedge clock);
    #1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int a2;
          beat(100 + i, 50, $urandom_range(0, 255), a2);
        end
      end
      begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("stall_in_ready_low", in_ready, 0);
        chk("stall_wr_en_held", wr_en, 1);
        repeat (2) @(posedge clock);
        #2;
        mem_mode = 1;
      end
    join
    drain();

    // Random beats mixed with out-of-range ones, random memory readiness.
    mem_mode = 1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 1500; i++) begin
      int x;
      int y;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      x = $urandom_range(0, 339);
      y = $urandom_range(0, 254);
      if ($urandom_range(0, 19) == 0) x = 2047;
      if ($urandom_range(0, 9) == 0) x = 319;
      if ($urandom_range(0, 9) == 0) y = 239;
      beat(x, y, $urandom_range(0, 255), acc);
    end
    drain();
    chk("random_drop_count", drop_count, drops);

    // Last lines of the raster at full throughput.
    mem_mode = 0;
    @(posedge clock);
    #1;
    base = fd_pulses;
    waits_sum = 0;
    for (int y = 237; y < 240; y++) begin
      for (int x = 0; x < 320; x++) begin
        beat(x, y, (x + y) & 255, acc);
        waits_sum += last_waits;
      end
    end
    drain();
    @(negedge clock);
    chk("raster_no_stall", waits_sum, 0);
    chk("raster_frame_done_pulses", fd_pulses - base, 1);
    chk("raster_drop_count", drop_count, drops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
